axi_cal_pulse_slave: RTL and testbench
======================================

// Module: axi_cal_pulse_slave
// PURPOSE
// AXI4-Lite slave terminating the S00_AXI port of the calibration-pulse IP.
// Four RW config registers: CTRL, PERIOD, WIDTH, NPULSE. Drives a gated
// calibration pulse train to the ASIC front-end. Sits behind the PS/BD
// interconnect; it is the responder to the AXI master VIP in the bfm design.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 supported
// C_S_AXI_ADDR_WIDTH  5   byte address width; decode uses [4:2]
// PORTS
// S_AXI_ACLK     in   1   clock
// S_AXI_ARESET   in   1   async reset, active-high
// S_AXI_AWADDR   in   5   write address
// S_AXI_AWPROT   in   3   ignored
// S_AXI_AWVALID/AWREADY  in/out 1  write-address handshake
// S_AXI_WDATA    in   32  write data
// S_AXI_WSTRB    in   4   byte enables
// S_AXI_WVALID/WREADY    in/out 1  write-data handshake
// S_AXI_BRESP    out  2   always 2'b00 (OKAY)
// S_AXI_BVALID/BREADY    out/in 1  write-response handshake
// S_AXI_ARADDR   in   5   read address
// S_AXI_ARPROT   in   3   ignored
// S_AXI_ARVALID/ARREADY  in/out 1  read-address handshake
// S_AXI_RDATA    out  32  read data
// S_AXI_RRESP    out  2   always 2'b00
// S_AXI_RVALID/RREADY    out/in 1  read-data handshake
// cal_pulse      out  1   calibration pulse to front-end
// cal_busy       out  1   pulse train in progress
// BEHAVIOUR
// Reset: all READY/VALID low, RDATA=0, all registers 0, cal_pulse=0, cal_busy=0.
// Map: 0x00 CTRL[0]=enable (bits 31:1 stored, no effect); 0x04 PERIOD;
//   0x08 WIDTH; 0x0C NPULSE. All RW, full 32 bits; readback == last write.
// Write: AWREADY and WREADY pulse together for 1 cycle when AWVALID&WVALID&!BVALID.
//   Register updates on that edge; each byte lane is gated by WSTRB.
//   BVALID rises next cycle and holds until BREADY. No new write is accepted
//   while BVALID=1. An AW without W (or W without AW) waits; nothing is accepted.
// Read: ARREADY pulses 1 cycle when ARVALID&!RVALID. RVALID+RDATA next cycle,
//   held stable until RREADY. No new AR is accepted while RVALID=1.
// Unmapped addresses (0x10-0x1C): write dropped with OKAY; read returns 0, OKAY.
// Read and write in the same cycle are independent. A read of a register written
//   in the same cycle returns the old value.
// Pulse FSM: IDLE -> RUN -> DONE.
//   IDLE->RUN: enable 0->1 write. PERIOD/WIDTH/NPULSE are latched into shadows.
//     phase counter=0; cal_pulse high from the next cycle.
//   RUN: cal_pulse = (phase < WIDTH_s). phase wraps at PERIOD_s-1.
//     Shadows reload from the registers at each wrap.
//     Each wrap increments pulse_cnt (32b).
//   RUN->DONE: NPULSE_s!=0 and pulse_cnt reaches NPULSE_s at a wrap. DONE: cal_pulse=0.
//   Any state -> IDLE when enable is written 0. cal_pulse drops the next cycle.
//   CTRL.enable is never auto-cleared. DONE->RUN needs enable 0 then 1.
//   cal_busy = (state==RUN).
// Edge cases: WIDTH=0 -> no pulse, but periods are still counted.
//   WIDTH>=PERIOD -> cal_pulse held high for the whole run.
//   PERIOD=0 is treated as PERIOD=1. NPULSE=0 -> runs forever.
// Async reset mid-transaction: outstanding B/R are dropped and the FSM goes to IDLE.
// CONFIGURATION
// CAL_PULSE_STATUS_REG_EN defined: 0x10 reads as a RO status word:
//   {pulse_cnt[29:0], state==DONE, cal_busy}. Writes to 0x10 are ignored.
// Not defined: 0x10 reads 0 and no status logic is built. pulse_cnt remains
//   internal.
// TESTING
// 1. Write 1,2,3,4 to 0x0,0x4,0x8,0xC; read back -> 1,2,3,4. All BRESP/RRESP=0.
// 2. After test 1 (enable=1, PERIOD=2, WIDTH=3, NPULSE=4) -> cal_pulse high
//    exactly 8 cycles starting the cycle after the CTRL write handshake.
//    cal_busy then falls.
// 3. PERIOD=10, WIDTH=3, NPULSE=2, enable 0->1 -> two 3-cycle pulses
//    with rising edges 10 cycles apart, then DONE.
// 4. PERIOD=0x100; write 0xFFFFFFFF with WSTRB=4'b0001 -> readback 0x000001FF.
// 5. Hold BREADY low 5 cycles, present a 2nd AW/W -> BVALID held,
//    AWREADY/WREADY stay low until the B handshake.
// 6. Assert S_AXI_ARESET mid-pulse with NPULSE=0 -> cal_pulse, cal_busy,
//    BVALID, RVALID all 0 immediately. Registers read 0 after release.

Source files
------------

// File: rtl/axi_cal_pulse_slave.sv
// AXI4-Lite slave for the calibration-pulse IP.
// Registers: CTRL (0x00, bit 0 = enable), PERIOD (0x04), WIDTH (0x08), NPULSE (0x0C).
// A pulse FSM drives a gated pulse train on cal_pulse. The train starts on an
// enable 0->1 write and stops on an enable 0 write.
// Optional feature: define CAL_PULSE_STATUS_REG_EN to make 0x10 a read-only status word.
module axi_cal_pulse_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            cal_pulse,
    output logic                            cal_busy
);
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t state, state_nxt;

    logic          wr_rdy, bvalid, arready, rvalid;
    logic [DW-1:0] rdata, rd_mux;
    logic [DW-1:0] ctrl_reg, period_reg, width_reg, npulse_reg;
    logic [DW-1:0] period_s, width_s, npulse_s, phase, pulse_cnt;
    logic [DW-1:0] per_eff, cnt_inc, ctrl_new;
    logic [2:0]    wr_idx, rd_idx;
    logic          wr_en, rd_en, ctrl_wr, en_rise, en_fall, wrap;
    logic          unused_bits;

    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];
    assign wr_en  = wr_rdy & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en  = arready & S_AXI_ARVALID;

    assign S_AXI_AWREADY = wr_rdy;
    assign S_AXI_WREADY  = wr_rdy;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Byte-lane merge of write data into an existing register value
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [DW/8-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < DW/8; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    assign ctrl_new = merge(ctrl_reg, S_AXI_WDATA, S_AXI_WSTRB);
    assign ctrl_wr  = wr_en && (wr_idx == 3'd0);
    assign en_rise  = ctrl_wr & ctrl_new[0] & ~ctrl_reg[0];
    assign en_fall  = ctrl_wr & ~ctrl_new[0];

    // Write channel: AW and W are taken together in one cycle; the B response is held until BREADY
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_rdy <= 1'b0;
            bvalid <= 1'b0;
        end else begin
            wr_rdy <= ~wr_rdy & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid;
            if (wr_en)             bvalid <= 1'b1;
            else if (S_AXI_BREADY) bvalid <= 1'b0;
        end
    end

    // Config register file; unmapped write addresses are silently dropped
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ctrl_reg   <= '0;
            period_reg <= '0;
            width_reg  <= '0;
            npulse_reg <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                3'd0:    ctrl_reg   <= ctrl_new;
                3'd1:    period_reg <= merge(period_reg, S_AXI_WDATA, S_AXI_WSTRB);
                3'd2:    width_reg  <= merge(width_reg,  S_AXI_WDATA, S_AXI_WSTRB);
                3'd3:    npulse_reg <= merge(npulse_reg, S_AXI_WDATA, S_AXI_WSTRB);
                default: ;
            endcase
        end
    end

    // Read data mux; the status word exists only when the option is built
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            3'd0: rd_mux = ctrl_reg;
            3'd1: rd_mux = period_reg;
            3'd2: rd_mux = width_reg;
            3'd3: rd_mux = npulse_reg;
`ifdef CAL_PULSE_STATUS_REG_EN
            3'd4: rd_mux = {pulse_cnt[29:0], state == ST_DONE, state == ST_RUN};
`endif
            default: rd_mux = '0;
        endcase
    end

    // Read channel: RDATA is captured at the AR handshake and held while RVALID is high
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= ~arready & S_AXI_ARVALID & ~rvalid;
            if (rd_en) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    // A PERIOD value of 0 behaves as 1, so the phase wraps every cycle
    assign per_eff = (period_s == '0) ? DW'(1) : period_s;
    assign wrap    = (state == ST_RUN) && (phase == per_eff - DW'(1));
    assign cnt_inc = pulse_cnt + DW'(1);

    // Pulse FSM state register
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    // Pulse FSM next state: an enable 0 write wins from any state
    always_comb begin
        state_nxt = state;
        if (en_fall)
            state_nxt = ST_IDLE;
        else if (en_rise)
            state_nxt = ST_RUN;
        else if (state == ST_RUN && wrap && npulse_s != '0 && cnt_inc == npulse_s)
            state_nxt = ST_DONE;
    end

    // Phase counter, period counter and shadow copies of the timing registers
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            phase     <= '0;
            pulse_cnt <= '0;
            period_s  <= '0;
            width_s   <= '0;
            npulse_s  <= '0;
        end else if (en_rise) begin
            phase     <= '0;
            pulse_cnt <= '0;
            period_s  <= period_reg;
            width_s   <= width_reg;
            npulse_s  <= npulse_reg;
        end else if (state == ST_RUN && !en_fall) begin
            if (wrap) begin
                phase     <= '0;
                pulse_cnt <= cnt_inc;
                period_s  <= period_reg;
                width_s   <= width_reg;
                npulse_s  <= npulse_reg;
            end else begin
                phase <= phase + DW'(1);
            end
        end
    end

    assign cal_busy  = (state == ST_RUN);
    assign cal_pulse = (state == ST_RUN) && (phase < width_s);

endmodule

// File: tb/tb_axi_cal_pulse_slave.sv
// Directed bench for axi_cal_pulse_slave: register access, pulse train shapes,
// strobes, unmapped addresses, B backpressure and reset during a pulse train.
module tb_axi_cal_pulse_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        cal_pulse, cal_busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] p_hist, b_hist;
    logic [31:0] rd_val;
    logic [1:0]  rd_rsp;

    always #5 clk = ~clk;

    axi_cal_pulse_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .cal_pulse(cal_pulse), .cal_busy(cal_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present AW+W and return #1 after the handshake edge
    task automatic wr_hs(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        chk("aw_w_ready", {30'b0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        wr_hs(a, d, s);
        bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 50);
        chk("bvalid", {31'b0, bvalid}, 32'd1);
        chk("bresp", {30'b0, bresp}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Issue AR and return at the first negedge where RVALID is seen
    task automatic rd_hs(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        chk("arready", {31'b0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 50);
        chk("rvalid", {31'b0, rvalid}, 32'd1);
        d = rdata; r = rresp;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        rready = 1'b1;
        rd_hs(a, d, r);
        chk({tag, "_rresp"}, {30'b0, r}, 32'd0);
        chk(tag, d, exp);
        @(posedge clk); #1;
    endtask

    // Record cal_pulse / cal_busy for cycles 1..n after the current edge
    task automatic observe(input int n);
        p_hist = '0; b_hist = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            p_hist[i] = cal_pulse;
            b_hist[i] = cal_busy;
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {24'b0, awready, wready, bvalid, arready, rvalid, cal_pulse, cal_busy, 1'b0}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Register write / readback
        wr(5'h00, 32'd1, 4'hF);
        wr(5'h04, 32'd2, 4'hF);
        wr(5'h08, 32'd3, 4'hF);
        wr(5'h0C, 32'd4, 4'hF);
        rd_chk("rb_ctrl",   5'h00, 32'd1);
        rd_chk("rb_period", 5'h04, 32'd2);
        rd_chk("rb_width",  5'h08, 32'd3);
        rd_chk("rb_npulse", 5'h0C, 32'd4);

        // PERIOD=2 WIDTH=3 NPULSE=4: 8 high cycles starting right after the CTRL handshake
        wr(5'h00, 32'd0, 4'hF);
        chk("idle_after_dis", {30'b0, cal_pulse, cal_busy}, 32'd0);
        wr_hs(5'h00, 32'd1, 4'hF);
        observe(12);
        chk("t2_high_count", $countones(p_hist), 32'd8);
        chk("t2_first_high", {31'b0, p_hist[1]}, 32'd1);
        chk("t2_last_high",  {31'b0, p_hist[8]}, 32'd1);
        chk("t2_after_low",  {31'b0, p_hist[9]}, 32'd0);
        chk("t2_busy_c8",    {31'b0, b_hist[8]}, 32'd1);
        chk("t2_busy_c9",    {31'b0, b_hist[9]}, 32'd0);
        rd_chk("enable_kept", 5'h00, 32'd1);

        // PERIOD=10 WIDTH=3 NPULSE=2: two 3-cycle pulses, 10 cycles apart, then DONE
        wr(5'h04, 32'd10, 4'hF);
        wr(5'h08, 32'd3, 4'hF);
        wr(5'h0C, 32'd2, 4'hF);
        wr(5'h00, 32'd0, 4'hF);
        wr_hs(5'h00, 32'd1, 4'hF);
        observe(30);
        chk("t3_pulse1", {22'b0, p_hist[10:1]},  32'h007);
        chk("t3_pulse2", {22'b0, p_hist[20:11]}, 32'h007);
        chk("t3_quiet",  {22'b0, p_hist[30:21]}, 32'h000);
        chk("t3_busy_c20", {31'b0, b_hist[20]}, 32'd1);
        chk("t3_busy_c21", {31'b0, b_hist[21]}, 32'd0);
`ifdef CAL_PULSE_STATUS_REG_EN
        rd_chk("status", 5'h10, 32'h0000000A);
`else
        rd_chk("status", 5'h10, 32'h00000000);
`endif
        // Writing enable=1 again from DONE must not restart
        wr(5'h00, 32'd1, 4'hF);
        repeat (2) @(negedge clk);
        chk("done_no_restart", {30'b0, cal_pulse, cal_busy}, 32'd0);

        // Byte strobes
        wr(5'h04, 32'h100, 4'hF);
        wr(5'h04, 32'hFFFFFFFF, 4'b0001);
        rd_chk("strb_lane0", 5'h04, 32'h000001FF);
        wr(5'h08, 32'hAABBCCDD, 4'b0100);
        rd_chk("strb_lane2", 5'h08, 32'h00BB0003);

        // Unmapped addresses
        wr(5'h14, 32'hDEADBEEF, 4'hF);
        rd_chk("unmapped_14", 5'h14, 32'd0);
        rd_chk("unmapped_1c", 5'h1C, 32'd0);

        // B backpressure blocks the next write
        bready = 1'b0;
        wr_hs(5'h08, 32'd5, 4'hF);
        awaddr = 5'h0C; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_bvalid_held", {31'b0, bvalid}, 32'd1);
            chk("bp_ready_low", {30'b0, awready, wready}, 32'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        wr(5'h0C, 32'd7, 4'hF);
        rd_chk("bp_first",  5'h08, 32'd5);
        rd_chk("bp_second", 5'h0C, 32'd7);

        // Reset during an endless pulse train with B and R outstanding
        wr(5'h04, 32'd4, 4'hF);
        wr(5'h08, 32'd8, 4'hF);
        wr(5'h0C, 32'd0, 4'hF);
        wr(5'h00, 32'd0, 4'hF);
        bready = 1'b0;
        wr_hs(5'h00, 32'd1, 4'hF);
        rready = 1'b0;
        rd_hs(5'h04, rd_val, rd_rsp);
        chk("pre_rst_state", {28'b0, cal_pulse, cal_busy, bvalid, rvalid}, 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", {28'b0, cal_pulse, cal_busy, bvalid, rvalid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        rd_chk("post_rst_ctrl",   5'h00, 32'd0);
        rd_chk("post_rst_period", 5'h04, 32'd0);
        rd_chk("post_rst_width",  5'h08, 32'd0);
        rd_chk("post_rst_npulse", 5'h0C, 32'd0);
        chk("post_rst_idle", {30'b0, cal_pulse, cal_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
